// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory to SRAM bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester at or after ptr wins, one-hot grant.
module rr_arbiter #(
    parameter int unsigned NUM_CHANNELS = 4,
    localparam int unsigned PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]        ptr,
    output logic [NUM_CHANNELS-1:0] gnt,
    output logic                    valid
);

    logic [PTR_W:0] pos;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            // ptr < NUM_CHANNELS and i < NUM_CHANNELS, so one subtract wraps
            pos = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (pos >= (PTR_W + 1)'(NUM_CHANNELS)) begin
                pos = pos - (PTR_W + 1)'(NUM_CHANNELS);
            end
            if (!valid && req[pos[PTR_W-1:0]]) begin
                gnt[pos[PTR_W-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Arbitrates per-channel read/write requests onto one single-port SRAM, one access at a time.
// Define DMEM_SRAM_BRIDGE_STATS_EN to add saturating read/write/stall counters.
module dmem_sram_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address[NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data   [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [ADDR_BITS-1:0]    sram_addr,
    output logic [DATA_BITS-1:0]    sram_wdata,
    input  logic [DATA_BITS-1:0]    sram_rdata
`ifdef DMEM_SRAM_BRIDGE_STATS_EN
    ,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_stall_cycles
`endif
);

    localparam int unsigned CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned WAIT_W = $clog2(RD_LATENCY_MAX);

    state_e                  state_q;
    logic [CH_W-1:0]         rr_ptr_q;
    logic [CH_W-1:0]         ch_q;
    logic                    op_write_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [NUM_CHANNELS-1:0] lock_q;

    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] gnt;
    logic                    gnt_valid;
    logic [CH_W-1:0]         gnt_idx;

    assign eligible = (mem_read_valid | mem_write_valid) & ~lock_q;

    rr_arbiter #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_rr_arbiter (
        .req  (eligible),
        .ptr  (rr_ptr_q),
        .gnt  (gnt),
        .valid(gnt_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (gnt[i]) begin
                gnt_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            ch_q            <= '0;
            op_write_q      <= 1'b0;
            wait_q          <= '0;
            lock_q          <= '0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            sram_en         <= 1'b0;
            sram_we         <= 1'b0;
            sram_addr       <= '0;
            sram_wdata      <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                mem_read_data[i] <= '0;
            end
        end else begin
            sram_en         <= 1'b0;
            sram_we         <= 1'b0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            unique case (state_q)
                StIdle: begin
                    lock_q <= '0;
                    if (gnt_valid) begin
                        state_q    <= StAccess;
                        ch_q       <= gnt_idx;
                        rr_ptr_q   <= (gnt_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
                        // A channel with both requests pending has its write served first
                        op_write_q <= mem_write_valid[gnt_idx];
                        sram_en    <= 1'b1;
                        sram_we    <= mem_write_valid[gnt_idx];
                        if (mem_write_valid[gnt_idx]) begin
                            sram_addr  <= mem_write_address[gnt_idx];
                            sram_wdata <= mem_write_data[gnt_idx];
                        end else begin
                            sram_addr <= mem_read_address[gnt_idx];
                        end
                    end
                end
                StAccess: begin
                    if (op_write_q) begin
                        state_q               <= StResp;
                        mem_write_ready[ch_q] <= 1'b1;
                    end else if (RD_LATENCY <= 1) begin
                        state_q              <= StResp;
                        mem_read_ready[ch_q] <= 1'b1;
                        mem_read_data[ch_q]  <= sram_rdata;
                    end else begin
                        state_q <= StWait;
                        wait_q  <= WAIT_W'(RD_LATENCY - 2);
                    end
                end
                StWait: begin
                    // sram_rdata is sampled on the RD_LATENCY-th edge after sram_en rises
                    if (wait_q == '0) begin
                        state_q              <= StResp;
                        mem_read_ready[ch_q] <= 1'b1;
                        mem_read_data[ch_q]  <= sram_rdata;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    lock_q       <= '0;
                    lock_q[ch_q] <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DMEM_SRAM_BRIDGE_STATS_EN
    logic [NUM_CHANNELS-1:0] busy_mask;
    logic                    stall;

    always_comb begin
        busy_mask       = '0;
        busy_mask[ch_q] = 1'b1;
        if (state_q == StIdle) begin
            stall = |(eligible & ~gnt);
        end else begin
            stall = |((mem_read_valid | mem_write_valid) & ~busy_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads        <= '0;
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (state_q == StResp) begin
                if (op_write_q) begin
                    stat_writes <= sat_inc(stat_writes);
                end else begin
                    stat_reads <= sat_inc(stat_reads);
                end
            end
            if (stall) begin
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench: one bridge at RD_LATENCY=1 and one at RD_LATENCY=3, each with an SRAM model.
module tb_dmem_sram_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // RD_LATENCY=1 instance
    logic [3:0] rv, wv, rr, wr;
    logic [7:0] ra [4];
    logic [7:0] wa [4];
    logic [7:0] wd [4];
    logic [7:0] rd [4];
    logic       en, we;
    logic [7:0] addr, wdata, rdata;
    logic [7:0] mem [256];
    bit         wflag [256];

    // RD_LATENCY=3 instance
    logic [3:0] rv3, wv3, rr3, wr3;
    logic [7:0] ra3 [4];
    logic [7:0] wa3 [4];
    logic [7:0] wd3 [4];
    logic [7:0] rd3 [4];
    logic       en3, we3;
    logic [7:0] addr3, wdata3, rdata3;
    logic [7:0] mem3 [256];
    bit         wflag3 [256];
    logic [7:0] pipe3 [2];

`ifdef DMEM_SRAM_BRIDGE_STATS_EN
    logic [31:0] sr, sw, ss, sr3, sw3, ss3;
`endif

    dmem_sram_bridge #(.RD_LATENCY(1)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_valid   (rv),
        .mem_read_address (ra),
        .mem_read_ready   (rr),
        .mem_read_data    (rd),
        .mem_write_valid  (wv),
        .mem_write_address(wa),
        .mem_write_data   (wd),
        .mem_write_ready  (wr),
        .sram_en          (en),
        .sram_we          (we),
        .sram_addr        (addr),
        .sram_wdata       (wdata),
        .sram_rdata       (rdata)
`ifdef DMEM_SRAM_BRIDGE_STATS_EN
        ,
        .stat_reads       (sr),
        .stat_writes      (sw),
        .stat_stall_cycles(ss)
`endif
    );

    dmem_sram_bridge #(.RD_LATENCY(3)) u_dut3 (
        .clk              (clk),
        .reset            (reset),
        .mem_read_valid   (rv3),
        .mem_read_address (ra3),
        .mem_read_ready   (rr3),
        .mem_read_data    (rd3),
        .mem_write_valid  (wv3),
        .mem_write_address(wa3),
        .mem_write_data   (wd3),
        .mem_write_ready  (wr3),
        .sram_en          (en3),
        .sram_we          (we3),
        .sram_addr        (addr3),
        .sram_wdata       (wdata3),
        .sram_rdata       (rdata3)
`ifdef DMEM_SRAM_BRIDGE_STATS_EN
        ,
        .stat_reads       (sr3),
        .stat_writes      (sw3),
        .stat_stall_cycles(ss3)
`endif
    );

    // Untouched SRAM words read as ~addr, except 0x10 which holds 0x5A
    function automatic logic [7:0] base(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : ~a;
    endfunction

    function automatic logic [7:0] sram1(input logic [7:0] a);
        return wflag[a] ? mem[a] : base(a);
    endfunction

    function automatic logic [7:0] sram3(input logic [7:0] a);
        return wflag3[a] ? mem3[a] : base(a);
    endfunction

    always @(posedge clk) begin
        if (en && we) begin
            mem[addr]   <= wdata;
            wflag[addr] <= 1'b1;
        end
    end
    always_comb rdata = en ? sram1(addr) : 8'hEE;

    always @(posedge clk) begin
        if (en3 && we3) begin
            mem3[addr3]   <= wdata3;
            wflag3[addr3] <= 1'b1;
        end
        pipe3[0] <= (en3 && !we3) ? sram3(addr3) : 8'hEE;
        pipe3[1] <= pipe3[0];
    end
    assign rdata3 = pipe3[1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // which: 0 = read ready, 1 = write ready, 2 = either (latency-1 bridge), 3 = read ready (latency-3)
    function automatic logic pulse(input int which, input int ch);
        case (which)
            0:       return rr[ch];
            1:       return wr[ch];
            2:       return rr[ch] | wr[ch];
            default: return rr3[ch];
        endcase
    endfunction

    task automatic wait_pulse(input int which, input int ch, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!pulse(which, ch) && cyc < 30);
    endtask

`ifdef DMEM_SRAM_BRIDGE_STATS_EN
    bit         opw [2][3];
    logic [7:0] opa [2][3];
    logic [7:0] opd [2][3];
    int         opn [2];
    int         idx [2];

    task automatic issue(input int ch);
        rv[ch] = 1'b0;
        wv[ch] = 1'b0;
        if (idx[ch] < opn[ch]) begin
            if (opw[ch][idx[ch]]) begin
                wv[ch] = 1'b1;
                wa[ch] = opa[ch][idx[ch]];
                wd[ch] = opd[ch][idx[ch]];
            end else begin
                rv[ch] = 1'b1;
                ra[ch] = opa[ch][idx[ch]];
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nen;
        int seen;
        int n;
        int multi;
        int last;
        int order [4];

        rv = '0; wv = '0; rv3 = '0; wv3 = '0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = '0;  wa[i] = '0;  wd[i] = '0;
            ra3[i] = '0; wa3[i] = '0; wd3[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_rready", rr, 0);
        check("rst_wready", wr, 0);
        check("rst_en_we", {en, we}, 0);
        check("rst_rdata", {rd[0], rd[1], rd[2], rd[3]}, 0);

        // Single read on ch0, latency 1
        ra[0] = 8'h10;
        rv[0] = 1'b1;
        tick();
        check("rd1_access_en_we", {en, we}, 2'b10);
        check("rd1_access_addr", addr, 8'h10);
        check("rd1_no_early_ready", rr, 0);
        tick();
        check("rd1_ready", rr, 4'b0001);
        check("rd1_data", rd[0], 8'h5A);
        // Keep ch0 requesting: it must sit out the first idle cycle
        tick();
        check("lock_idle", {rr, en}, 0);
        tick();
        check("lock_skip", en, 0);
        tick();
        check("lock_grant", en, 1);
        tick();
        check("lock_ready", rr, 4'b0001);
        rv[0] = 1'b0;
        tick();
        tick();

        // Write ch2 then read it back on ch1
        wa[2] = 8'h20; wd[2] = 8'hC3; wv[2] = 1'b1;
        wait_pulse(1, 2, cyc);
        check("wr_latency", cyc, 2);
        check("wr_ready_onehot", wr, 4'b0100);
        check("wr_sram_contents", sram1(8'h20), 8'hC3);
        wv[2] = 1'b0;
        tick();
        ra[1] = 8'h20; rv[1] = 1'b1;
        wait_pulse(0, 1, cyc);
        check("rdback_latency", cyc, 2);
        check("rdback_data", rd[1], 8'hC3);
        rv[1] = 1'b0;
        tick();
        tick();

        // ch3 raises read and write together: write goes first
        wa[3] = 8'h70; wd[3] = 8'h99; ra[3] = 8'h70;
        wv[3] = 1'b1; rv[3] = 1'b1;
        wait_pulse(2, 3, cyc);
        check("wfirst_wready", wr[3], 1);
        check("wfirst_rready", rr[3], 0);
        wv[3] = 1'b0;
        wait_pulse(0, 3, cyc);
        check("wfirst_read_latency", cyc, 4);
        check("wfirst_read_data", rd[3], 8'h99);
        rv[3] = 1'b0;
        tick();
        tick();

        // Latency-3 read: ready 4 cycles after grant, one strobe cycle
        ra3[0] = 8'h33; rv3[0] = 1'b1;
        cyc = 0; nen = 0;
        do begin
            tick();
            cyc++;
            nen += int'(en3);
        end while (!rr3[0] && cyc < 30);
        check("lat3_latency", cyc, 4);
        check("lat3_en_cycles", nen, 1);
        check("lat3_data", rd3[0], 8'hCC);
        rv3[0] = 1'b0;
        tick();
        tick();

        // Reset while the latency-3 bridge sits in WAIT
        ra3[1] = 8'h44; rv3[1] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstwait_rready", rr3, 0);
        check("rstwait_en_we", {en3, we3}, 0);
        check("rstwait_rdata", {rd3[0], rd3[1]}, 0);
        check("rstwait_other_rdata", rd[3], 0);
        rv3[1] = 1'b0;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            seen += $countones(rr3);
        end
        check("rstwait_no_ready", seen, 0);
        rv3[1] = 1'b1;
        wait_pulse(3, 1, cyc);
        check("rstwait_fresh_latency", cyc, 4);
        check("rstwait_fresh_data", rd3[1], 8'hBB);
        rv3[1] = 1'b0;
        tick();
        tick();

        // All four channels read at once, pointer fresh from reset
        for (int k = 0; k < 4; k++) ra[k] = 8'(k + 1);
        rv = 4'hF;
        n = 0; multi = 0; last = 0;
        for (int t = 1; t <= 40 && n < 4; t++) begin
            tick();
            if ($countones(rr) > 1) multi++;
            for (int k = 0; k < 4; k++) begin
                if (rr[k]) begin
                    if (n < 4) order[n] = k;
                    n++;
                    rv[k] = 1'b0;
                    last = t;
                end
            end
        end
        check("rr_count", n, 4);
        check("rr_multi_ready", multi, 0);
        check("rr_order", {4'(order[0]), 4'(order[1]), 4'(order[2]), 4'(order[3])}, 16'h0123);
        check("rr_last_ready_cycle", last, 11);
        check("rr_data", {rd[0], rd[1], rd[2], rd[3]}, 32'hFEFDFCFB);
        rv = '0;
        tick();
        tick();

`ifdef DMEM_SRAM_BRIDGE_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("stat_rst", {sr[7:0], sw[7:0], ss[7:0]}, 0);
        opn[0] = 3; opn[1] = 2;
        opw[0][0] = 1'b1; opa[0][0] = 8'h50; opd[0][0] = 8'h11;
        opw[0][1] = 1'b0; opa[0][1] = 8'h50; opd[0][1] = 8'h00;
        opw[0][2] = 1'b0; opa[0][2] = 8'h51; opd[0][2] = 8'h00;
        opw[1][0] = 1'b1; opa[1][0] = 8'h60; opd[1][0] = 8'h22;
        opw[1][1] = 1'b0; opa[1][1] = 8'h60; opd[1][1] = 8'h00;
        opw[1][2] = 1'b0; opa[1][2] = 8'h00; opd[1][2] = 8'h00;
        idx[0] = 0; idx[1] = 0;
        issue(0);
        issue(1);
        for (int t = 0; t < 80 && !(idx[0] >= 3 && idx[1] >= 2); t++) begin
            tick();
            for (int ch = 0; ch < 2; ch++) begin
                if (rr[ch] | wr[ch]) begin
                    idx[ch]++;
                    issue(ch);
                end
            end
        end
        check("stat_traffic_done", (idx[0] >= 3 && idx[1] >= 2), 1);
        tick();
        tick();
        check("stat_reads", sr, 3);
        check("stat_writes", sw, 2);
        check("stat_stall_nonzero", (ss != 0), 1);
        check("stat_ch0_data", rd[0], 8'hAE);
        check("stat_ch1_data", rd[1], 8'h22);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: valid/ready channels accepted from the GPU data-memory side.
REQ-002 Parameter ADDR_BITS, default 8: address width.
REQ-003 Parameter DATA_BITS, default 8: data width.
REQ-004 Parameter RD_LATENCY, default 1, legal 1..4: cycles from sram_en to valid sram_rdata.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mem_read_valid  in  [NUM_CHANNELS]  per-channel read request, held until mem_read_ready.
REQ-008 mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS (unpacked)  read address.
REQ-009 mem_read_ready  out  [NUM_CHANNELS]  one-cycle pulse, read data valid.
REQ-010 mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, held until next read on that channel.
REQ-011 mem_write_valid  in  [NUM_CHANNELS]  per-channel write request, held until mem_write_ready.
REQ-012 mem_write_address / mem_write_data  in  [ADDR_BITS] / [DATA_BITS] x NUM_CHANNELS  write target and value.
REQ-013 mem_write_ready  out  [NUM_CHANNELS]  one-cycle pulse, write committed.
REQ-014 sram_en, sram_we  out  1, 1  single-port SRAM access strobe and write enable.
REQ-015 sram_addr, sram_wdata  out  [ADDR_BITS], [DATA_BITS]  SRAM address and write data.
REQ-016 sram_rdata  in  [DATA_BITS]  SRAM read data, valid RD_LATENCY cycles after a read strobe.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, WAIT, RESP; exactly one SRAM access outstanding.
REQ-018 In IDLE, requests are eligible when valid and not locked out; grant is round-robin over channels from the channel after the last granted; no eligible request keeps IDLE.
REQ-019 If a channel has read and write valid together, the write SHALL be served first.
REQ-020 IDLE->ACCESS on grant; request type, channel, address and write data are registered.
REQ-021 ACCESS drives sram_en=1 for exactly one cycle; sram_we=1 for writes only.
REQ-022 Read: ACCESS->WAIT for RD_LATENCY-1 cycles (skipped if RD_LATENCY=1), then RESP; sram_rdata captured into mem_read_data[ch] on entering RESP.
REQ-023 Write: ACCESS->RESP directly.
REQ-024 RESP pulses exactly one ready bit for the granted channel for one cycle, then ->IDLE.
REQ-025 Read latency is RD_LATENCY+1 cycles from the IDLE grant cycle to ready; write latency is 2 cycles.
REQ-026 The channel just responded SHALL be ineligible in the first IDLE cycle after RESP (requester deassert slack).
REQ-027 Outside ACCESS, sram_en=0, sram_we=0; sram_addr/sram_wdata hold.
REQ-028 A request deasserted before grant is silently dropped; one deasserted after grant is still completed and its ready still pulsed.

Reset
REQ-029 reset SHALL force IDLE, round-robin pointer 0, all ready outputs 0, sram_en/sram_we 0, all mem_read_data 0, lockout cleared, even mid-ACCESS/WAIT/RESP; no ready pulse for an aborted access.

Configuration
REQ-030 With DMEM_SRAM_BRIDGE_STATS_EN defined: outputs stat_reads, stat_writes, stat_stall_cycles (32 bits each) count completed reads, completed writes, and cycles with any eligible request not granted; they saturate at all-ones and clear on reset.
REQ-031 Without DMEM_SRAM_BRIDGE_STATS_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-032 The shared package dmem_pkg SHALL hold the FSM state enum and the RD_LATENCY legal range constants.
REQ-033 The round-robin selector SHALL be a sub-module rr_arbiter (request vector, pointer in, one-hot grant and valid out).

Verification
REQ-034 Single read ch0, addr 0x10, SRAM holds 0x5A, RD_LATENCY=1 -> mem_read_ready[0] one pulse 2 cycles after grant, mem_read_data[0]=0x5A.
REQ-035 Write ch2 addr 0x20 data 0xC3, then read ch1 addr 0x20 -> write_ready[2] after 2 cycles; read returns 0xC3.
REQ-036 All 4 channels read together, requests held -> grants in order 0,1,2,3, one ready per access, never two readies in one cycle.
REQ-037 RD_LATENCY=3 read -> ready 4 cycles after grant, sram_en high exactly one cycle.
REQ-038 reset asserted in WAIT -> no ready pulse, all outputs at reset values next cycle; a fresh read then completes normally.
REQ-039 With DMEM_SRAM_BRIDGE_STATS_EN, 3 reads and 2 writes on 2 channels at once -> stat_reads=3, stat_writes=2, stat_stall_cycles nonzero.
